// File: rtl/aes_rcon_pkg.sv
// Shared types, per-mode constants and the GF(2^8) doubling helper for the
// AES key-schedule descriptor sequencer.
package aes_rcon_pkg;

  typedef enum logic [1:0] {AES128 = 2'd0, AES192 = 2'd1, AES256 = 2'd2} mode_e;
  typedef enum logic [1:0] {OP_XOR = 2'd0, OP_ROTSUB = 2'd1, OP_SUB = 2'd2} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_e;

  localparam int unsigned NK_128   = 4;
  localparam int unsigned NK_192   = 6;
  localparam int unsigned NK_256   = 8;
  localparam int unsigned LAST_128 = 43;
  localparam int unsigned LAST_192 = 51;
  localparam int unsigned LAST_256 = 59;

  localparam logic [7:0] RCON_POLY = 8'h1b;

  function automatic int unsigned nk_of(mode_e m);
    case (m)
      AES192:  return NK_192;
      AES256:  return NK_256;
      default: return NK_128;
    endcase
  endfunction

  function automatic int unsigned last_of(mode_e m);
    case (m)
      AES192:  return LAST_192;
      AES256:  return LAST_256;
      default: return LAST_128;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_rcon_sched.sv
// Key-expansion sequencer: streams one (index, op, rcon) descriptor per
// expanded word over a valid/ready handshake for AES-128/192/256.
//
// state  | meaning
// IDLE   | no schedule loaded, or last kld carried an illegal mode
// RUN    | presenting descriptors, advancing on each acceptance
// DONE   | last word accepted, descriptor held until next kld
module aes_rcon_sched
  import aes_rcon_pkg::*;
#(
  parameter int         IDX_W       = 6,
  parameter logic [7:0] RCON_INIT   = 8'h01,
  parameter bit         SUPPORT_256 = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kld_i,
  input  logic [1:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IDX_W-1:0] word_idx_o,
  output logic [1:0]       op_o,
  output logic [31:0]      rcon_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [2:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       rbyte_q, rbyte_d;
  op_e              op_q, op_d;
  logic [31:0]      rcon_q, rcon_d;
  logic             err_q, err_d;

  logic             legal;
  logic             wrap;
  logic [2:0]       phase_nx;
  logic [7:0]       rbyte_nx;
  op_e              op_nx;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] kld_nk;

  assign legal    = (mode_i != 2'd3) && ((mode_i != 2'd2) || SUPPORT_256);
  assign wrap     = (phase_q == 3'(nk_of(mode_q) - 1));
  assign phase_nx = wrap ? 3'd0 : phase_q + 3'd1;
  assign rbyte_nx = wrap ? xtime(rbyte_q) : rbyte_q;
  assign last_idx = IDX_W'(last_of(mode_q));
  assign kld_nk   = IDX_W'(nk_of(mode_e'(mode_i)));

  // Operation of the word that follows the current one.
  always_comb begin
    op_nx = OP_XOR;
    if (phase_nx == 3'd0) begin
      op_nx = OP_ROTSUB;
    end else if (mode_q == AES256 && phase_nx == 3'd4) begin
      op_nx = OP_SUB;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    rbyte_d = rbyte_q;
    op_d    = op_q;
    rcon_d  = rcon_q;
    err_d   = err_q;
    if (kld_i) begin
      phase_d = 3'd0;
      rbyte_d = RCON_INIT;
      if (legal) begin
        state_d = S_RUN;
        mode_d  = mode_e'(mode_i);
        idx_d   = kld_nk;
        op_d    = OP_ROTSUB;
        rcon_d  = {RCON_INIT, 24'h0};
        err_d   = 1'b0;
      end else begin
        state_d = S_IDLE;
        idx_d   = '0;
        op_d    = OP_XOR;
        rcon_d  = 32'h0;
        err_d   = 1'b1;
      end
    end else if (state_q == S_RUN && out_ready_i) begin
      if (idx_q == last_idx) begin
        state_d = S_DONE;
      end else begin
        phase_d = phase_nx;
        rbyte_d = rbyte_nx;
        idx_d   = idx_q + IDX_W'(1);
        op_d    = op_nx;
        rcon_d  = (op_nx == OP_ROTSUB) ? {rbyte_nx, 24'h0} : 32'h0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= AES128;
      phase_q <= 3'd0;
      idx_q   <= '0;
      rbyte_q <= RCON_INIT;
      op_q    <= OP_XOR;
      rcon_q  <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      rbyte_q <= rbyte_d;
      op_q    <= op_d;
      rcon_q  <= rcon_d;
      err_q   <= err_d;
    end
  end

  assign out_valid_o = (state_q == S_RUN);
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign err_o       = err_q;
  assign word_idx_o  = idx_q;
  assign op_o        = op_q;
  assign rcon_o      = rcon_q;

endmodule

// File: tb/tb_aes_rcon_sched.sv
// Self-checking bench for aes_rcon_sched: a reference descriptor stream is
// queued at kld time and popped as the DUT hands each descriptor over.
module tb_aes_rcon_sched;

  typedef struct packed {
    logic [5:0]  idx;
    logic [1:0]  op;
    logic [31:0] rcon;
  } desc_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        kld_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [5:0]  word_idx_o;
  logic [1:0]  op_o;
  logic [31:0] rcon_o;
  logic        busy_o, done_o, err_o;

  int checks = 0;
  int errors = 0;
  desc_t sb[$];
  desc_t last_exp;
  logic [7:0] rc_tbl[10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_rcon_sched #(.IDX_W(6), .RCON_INIT(8'h01), .SUPPORT_256(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .kld_i(kld_i), .mode_i(mode_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .word_idx_o(word_idx_o), .op_o(op_o), .rcon_o(rcon_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  function automatic desc_t model(int i, int nk);
    desc_t d;
    d.idx  = 6'(i);
    d.op   = 2'd0;
    d.rcon = 32'h0;
    if (i % nk == 0) begin
      d.op   = 2'd1;
      d.rcon = {rc_tbl[i / nk - 1], 24'h0};
    end else if (nk == 8 && i % 8 == 4) begin
      d.op = 2'd2;
    end
    return d;
  endfunction

  task automatic push_stream(int m);
    int nk;
    int last;
    nk   = (m == 0) ? 4 : (m == 1) ? 6 : 8;
    last = (m == 0) ? 43 : (m == 1) ? 51 : 59;
    sb.delete();
    for (int i = nk; i <= last; i++) sb.push_back(model(i, nk));
    last_exp = model(last, nk);
  endtask

  // Called at a negedge; returns at the negedge after the kld cycle.
  task automatic load(logic [1:0] m);
    kld_i  = 1'b1;
    mode_i = m;
    @(negedge clk);
    kld_i = 1'b0;
  endtask

  task automatic consume(int pct, string name);
    int    cyc = 0;
    bit    stalled = 0;
    desc_t prev, got, exp;
    while (sb.size() > 0 && cyc < 3000) begin
      got = {word_idx_o, op_o, rcon_o};
      checks++;
      if (out_valid_o !== 1'b1) begin
        errors++;
        $display("FAIL %s valid got %b exp 1 (%0d words left)", name, out_valid_o, sb.size());
      end else begin
        if (stalled) begin
          checks++;
          if (got !== prev) begin
            errors++;
            $display("FAIL %s stall_hold got %h exp %h", name, got, prev);
          end
        end
        out_ready_i = ($urandom_range(0, 99) < pct);
        if (out_ready_i) begin
          exp = sb.pop_front();
          checks++;
          if (got !== exp) begin
            errors++;
            $display("FAIL %s desc got idx %0d op %0d rcon %h exp idx %0d op %0d rcon %h",
                     name, got.idx, got.op, got.rcon, exp.idx, exp.op, exp.rcon);
          end
          stalled = 0;
        end else begin
          stalled = 1;
          prev = got;
        end
      end
      mode_i = 2'($urandom_range(0, 3));
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s timeout got %0d words left exp 0", name, sb.size());
    end
    checks++;
    if ({out_valid_o, busy_o, done_o, word_idx_o, op_o, rcon_o} !==
        {1'b0, 1'b0, 1'b1, last_exp.idx, last_exp.op, last_exp.rcon}) begin
      errors++;
      $display("FAIL %s end got v%b b%b d%b idx %0d op %0d rcon %h exp v0 b0 d1 idx %0d op %0d rcon %h",
               name, out_valid_o, busy_o, done_o, word_idx_o, op_o, rcon_o,
               last_exp.idx, last_exp.op, last_exp.rcon);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid_o, busy_o, done_o, err_o, word_idx_o, op_o, rcon_o} !== '0) begin
      errors++;
      $display("FAIL reset got v%b b%b d%b e%b idx %0d op %0d rcon %h exp all 0",
               out_valid_o, busy_o, done_o, err_o, word_idx_o, op_o, rcon_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_ready();
    for (int m = 0; m < 3; m++) begin
      push_stream(m);
      out_ready_i = 1'b1;
      load(2'(m));
      consume(100, $sformatf("ready1_mode%0d", m));
    end
  endtask

  task automatic test_backpressure();
    for (int m = 0; m < 3; m++) begin
      push_stream(m);
      out_ready_i = 1'b0;
      load(2'(m));
      consume(30, $sformatf("bp_mode%0d", m));
    end
  endtask

  task automatic test_mid_run_kld();
    int cyc = 0;
    out_ready_i = 1'b1;
    load(2'd0);
    while (word_idx_o != 6'd20 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if ({word_idx_o, op_o, rcon_o} !== {6'd20, 2'd1, 32'h1000_0000}) begin
      errors++;
      $display("FAIL midrun_pre got idx %0d op %0d rcon %h exp idx 20 op 1 rcon 10000000",
               word_idx_o, op_o, rcon_o);
    end
    push_stream(2);
    out_ready_i = 1'b1;
    load(2'd2);
    checks++;
    if ({out_valid_o, word_idx_o, op_o, rcon_o} !== {1'b1, 6'd8, 2'd1, 32'h0100_0000}) begin
      errors++;
      $display("FAIL midrun_restart got v%b idx %0d op %0d rcon %h exp v1 idx 8 op 1 rcon 01000000",
               out_valid_o, word_idx_o, op_o, rcon_o);
    end
    consume(100, "midrun_256");
  endtask

  task automatic test_illegal_and_async_reset();
    out_ready_i = 1'b1;
    load(2'd3);
    checks++;
    if ({err_o, out_valid_o, busy_o, done_o} !== 4'b1000) begin
      errors++;
      $display("FAIL illegal got e%b v%b b%b d%b exp e1 v0 b0 d0",
               err_o, out_valid_o, busy_o, done_o);
    end
    mode_i = 2'd1;
    repeat (2) @(negedge clk);
    checks++;
    if ({err_o, out_valid_o} !== 2'b10) begin
      errors++;
      $display("FAIL illegal_hold got e%b v%b exp e1 v0", err_o, out_valid_o);
    end
    load(2'd0);
    checks++;
    if ({err_o, out_valid_o, busy_o, word_idx_o, op_o, rcon_o} !==
        {1'b0, 1'b1, 1'b1, 6'd4, 2'd1, 32'h0100_0000}) begin
      errors++;
      $display("FAIL legal_after_err got e%b v%b b%b idx %0d op %0d rcon %h exp e0 v1 b1 idx 4 op 1 rcon 01000000",
               err_o, out_valid_o, busy_o, word_idx_o, op_o, rcon_o);
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid_o, busy_o, done_o, err_o, word_idx_o, op_o, rcon_o} !== '0) begin
      errors++;
      $display("FAIL async_reset got v%b b%b d%b e%b idx %0d op %0d rcon %h exp all 0",
               out_valid_o, busy_o, done_o, err_o, word_idx_o, op_o, rcon_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_ready();
    test_backpressure();
    test_mid_run_kld();
    test_illegal_and_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_rcon_sched.md
Name: aes_rcon_sched

Overview:
- Parametrised key-expansion sequencer for the AES key schedule; successor to the fixed AES-128 round-constant generator.
- Supports AES-128, AES-192 and AES-256 (Nk = 4/6/8).
- For every expanded word index i it emits a descriptor: word index, word operation (plain XOR, RotWord+SubWord+Rcon, or SubWord only) and the 32-bit round constant.
- Sits between the key-load logic and the key-expansion datapath; the consumer pulls descriptors via a valid/ready handshake.

Parameters:
- IDX_W, 6, width of word_idx; must be >= 6 to reach index 59.
- RCON_INIT, 8'h01, first round-constant byte.
- SUPPORT_256, 1, if 0 then mode AES-256 is rejected as illegal.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- kld, input, 1, start/restart strobe; samples mode.
- mode, input, 2, 0 = AES-128, 1 = AES-192, 2 = AES-256, 3 = reserved.
- out_valid, output, 1, descriptor valid.
- out_ready, input, 1, consumer accepts descriptor.
- word_idx, output, IDX_W, expanded word index i.
- op, output, 2, 0 = XOR, 1 = ROTSUB, 2 = SUB, 3 unused.
- rcon, output, 32, {rcon_byte, 24'h0} when op = ROTSUB, else 32'h0.
- busy, output, 1, high in RUN.
- done, output, 1, high in DONE.
- err, output, 1, illegal mode latched at kld.

Behaviour:
- Reset values: state IDLE, out_valid 0, word_idx 0, op 0, rcon 0, busy 0, done 0, err 0. Internal rcon byte = RCON_INIT, phase 0.
- States and transitions:
  - IDLE -> RUN on kld with a legal mode.
  - RUN -> DONE on acceptance of the last word.
  - Any state -> RUN on kld (restart from the first word, mode resampled).
  - kld with an illegal mode -> IDLE with err = 1. Illegal means mode = 3, or mode = 2 with SUPPORT_256 = 0.
  - err clears on the next kld with a legal mode.
- Word ranges:
  - AES-128: i = 4..43, 40 words.
  - AES-192: i = 6..51, 46 words.
  - AES-256: i = 8..59, 52 words.
- kld in cycle t:
  - Mode is latched.
  - In cycle t+1: out_valid = 1, word_idx = Nk, op = ROTSUB, rcon = {RCON_INIT, 24'h0}.
- Acceptance is out_valid & out_ready. The descriptor advances in the following cycle.
- While out_valid & !out_ready, all outputs hold stable. out_valid never depends combinationally on out_ready.
- Operation per word:
  - ROTSUB when i mod Nk = 0.
  - SUB when Nk = 8 and i mod 8 = 4.
  - XOR otherwise.
- Counters:
  - A phase counter (i mod Nk) is used; no divider.
  - Phase wraps from Nk-1 to 0.
  - On acceptance of a word with phase = Nk-1, the rcon byte updates to xtime(byte), where xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00).
- Last word accepted:
  - out_valid falls next cycle; state DONE; done = 1 until next kld.
  - word_idx holds the last index and op/rcon hold.
- kld has priority over a simultaneous acceptance; the accepted descriptor is discarded.
- Async reset mid-run returns all state to the reset values immediately.
- mode changes while not at kld have no effect.

Decomposition:
- Package aes_rcon_pkg:
  - mode enum (AES128/AES192/AES256), op enum (XOR/ROTSUB/SUB).
  - Per-mode constants NK and LAST_IDX (43/51/59).
  - RCON polynomial 8'h1b.
  - xtime function.
- No sub-module. The FSM, phase/index counters and rcon register sit in one module of about 150-200 lines.

Test Plan:
- AES-128, out_ready = 1:
  - ROTSUB at idx 4, 8, ..., 40 with rcon bytes 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
  - All other ops XOR.
  - 40 handshakes, then done = 1 and out_valid = 0.
- AES-192:
  - ROTSUB at idx 6, 12, ..., 48 with rcon 01..80 (byte 80 at idx 48).
  - Last idx 51, 46 words, then done.
- AES-256:
  - idx 8 ROTSUB rcon 01; idx 12 op = SUB, rcon = 0.
  - idx 56 ROTSUB rcon 40; last idx 59, then done.
- Backpressure:
  - Random out_ready (about 30% duty).
  - Outputs must be stable while stalled.
  - The descriptor stream must be identical to the ready = 1 run.
- Mid-run kld:
  - kld at idx 20 in AES-128 mode with mode = 2 and out_ready = 1 in the same cycle.
  - Next cycle: idx 8, ROTSUB, rcon 01000000; the stream continues as AES-256.
- Illegal mode:
  - kld with mode = 3 -> err = 1, IDLE, out_valid = 0.
  - A following kld with mode = 0 clears err and starts at idx 4.
  - Assert rst_n during RUN -> all outputs 0 in the same cycle.
